// File: rtl/binary_quiz_engine.sv
// ============================================================================
// binary_quiz_engine
// ----------------------------------------------------------------------------
// Reaction/quiz game for a row of DIP switches. A free-running 16-bit LFSR
// supplies random non-zero targets. The player scores a hit by holding the
// switches equal to the target for STABLE_CYC consecutive cycles. In timed
// mode each round has a limit of TIMEOUT_CYC cycles, and every timeout costs
// one life. The game is won after ROUNDS hits and lost when the last life is
// gone.
//
// Ports
//   clk           system clock; every register updates on the rising edge
//   rst           synchronous, active-high reset
//   start         level; starts a game from IDLE or restarts one from OVER
//   timed         mode select, latched at game start (1 = timed with lives)
//   guess         player's switch value
//   target        number to reproduce; 0 outside PLAY
//   target_valid  high exactly while in PLAY
//   score         hits in the current game
//   lives_left    remaining lives (stays at LIVES in free play)
//   hit_pulse     one-cycle strobe, high in the HIT cycle
//   miss_pulse    one-cycle strobe, high in the MISS cycle
//   game_over     high in OVER
//   win           high in OVER when the game ended by reaching ROUNDS
//
// Legal parameter ranges: WIDTH 2..16, ROUNDS 1..255, LIVES 1..15,
// TIMEOUT_CYC >= 2, STABLE_CYC >= 1, SEED != 0.
// ============================================================================
module binary_quiz_engine #(
    parameter int          WIDTH       = 8,
    parameter int          ROUNDS      = 10,
    parameter int          LIVES       = 3,
    parameter int          TIMEOUT_CYC = 50_000_000,
    parameter int          STABLE_CYC  = 1024,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             timed,
    input  logic [WIDTH-1:0] guess,
    output logic [WIDTH-1:0] target,
    output logic             target_valid,
    output logic [7:0]       score,
    output logic [3:0]       lives_left,
    output logic             hit_pulse,
    output logic             miss_pulse,
    output logic             game_over,
    output logic             win
);

    // The round timer counts 0..TIMEOUT_CYC-1. The match counter counts
    // 0..STABLE_CYC-1. Each counter is sized to its own range.
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int MW = (STABLE_CYC > 1)  ? $clog2(STABLE_CYC)  : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(STABLE_CYC - 1);
    localparam logic [7:0]    ROUNDS_V   = 8'(ROUNDS);
    localparam logic [3:0]    LIVES_V    = 4'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_HIT,
        S_MISS,
        S_OVER
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t          state;
    logic [15:0]     lfsr;
    logic            timed_q;
    logic [MW-1:0]   match_cnt;
    logic [TW-1:0]   timer;

    // Next-state values, computed combinationally
    state_t          state_d;
    logic            timed_d;
    logic [MW-1:0]   match_d;
    logic [TW-1:0]   timer_d;
    logic [WIDTH-1:0] target_d;
    logic            target_valid_d;
    logic [7:0]      score_d;
    logic [3:0]      lives_d;
    logic            hit_d;
    logic            miss_d;
    logic            over_d;
    logic            win_d;

    // Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10).
    logic            lfsr_fb;
    logic [WIDTH-1:0] candidate;
    logic            guess_eq;
    logic            hit_now;
    logic            timeout_now;

    assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign candidate   = lfsr[WIDTH-1:0];
    assign guess_eq    = (guess == target);
    // A hit needs STABLE_CYC matching cycles in a row: the counter already
    // holds STABLE_CYC-1 earlier matches, and this cycle also matches.
    assign hit_now     = guess_eq && (match_cnt == MATCH_LAST);
    assign timeout_now = timed_q && (timer == TIMER_LAST);

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned; otherwise synthesis infers a latch.
        state_d        = state;
        timed_d        = timed_q;
        match_d        = match_cnt;
        timer_d        = timer;
        target_d       = target;
        target_valid_d = target_valid;
        score_d        = score;
        lives_d        = lives_left;
        hit_d          = 1'b0;
        miss_d         = 1'b0;
        over_d         = game_over;
        win_d          = win;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    timed_d = timed;
                    score_d = 8'd0;
                    lives_d = LIVES_V;
                end
            end

            S_LOAD: begin
                // Zero is never a valid target. A candidate equal to the
                // current switches would score for free, so draw again.
                if ((candidate != '0) && (candidate != guess)) begin
                    state_d        = S_PLAY;
                    target_d       = candidate;
                    target_valid_d = 1'b1;
                    match_d        = '0;
                    timer_d        = '0;
                end
            end

            S_PLAY: begin
                if (hit_now) begin
                    // A hit wins over a timeout in the same cycle.
                    state_d        = S_HIT;
                    hit_d          = 1'b1;
                    score_d        = (score == 8'hFF) ? score : score + 8'd1;
                    target_d       = '0;
                    target_valid_d = 1'b0;
                    match_d        = '0;
                end else if (timeout_now) begin
                    state_d        = S_MISS;
                    miss_d         = 1'b1;
                    lives_d        = lives_left - 4'd1;
                    target_d       = '0;
                    target_valid_d = 1'b0;
                    match_d        = '0;
                end else begin
                    match_d = guess_eq ? match_cnt + 1'b1 : '0;
                    timer_d = timed_q ? timer + 1'b1 : '0;
                end
            end

            S_HIT: begin
                // score already holds the incremented value in this cycle.
                if (score == ROUNDS_V) begin
                    state_d = S_OVER;
                    over_d  = 1'b1;
                    win_d   = 1'b1;
                end else begin
                    state_d = S_LOAD;
                end
            end

            S_MISS: begin
                if (lives_left == 4'd0) begin
                    state_d = S_OVER;
                    over_d  = 1'b1;
                    win_d   = 1'b0;
                end else begin
                    state_d = S_LOAD;
                end
            end

            S_OVER: begin
                if (start) begin
                    state_d = S_LOAD;
                    timed_d = timed;
                    score_d = 8'd0;
                    lives_d = LIVES_V;
                    over_d  = 1'b0;
                    win_d   = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that all
        // registers sample their inputs as they were before this edge.
        if (rst) begin
            state        <= S_IDLE;
            lfsr         <= SEED;
            timed_q      <= 1'b0;
            match_cnt    <= '0;
            timer        <= '0;
            target       <= '0;
            target_valid <= 1'b0;
            score        <= 8'd0;
            lives_left   <= LIVES_V;
            hit_pulse    <= 1'b0;
            miss_pulse   <= 1'b0;
            game_over    <= 1'b0;
            win          <= 1'b0;
        end else begin
            state        <= state_d;
            lfsr         <= {lfsr[14:0], lfsr_fb};
            timed_q      <= timed_d;
            match_cnt    <= match_d;
            timer        <= timer_d;
            target       <= target_d;
            target_valid <= target_valid_d;
            score        <= score_d;
            lives_left   <= lives_d;
            hit_pulse    <= hit_d;
            miss_pulse   <= miss_d;
            game_over    <= over_d;
            win          <= win_d;
        end
    end

endmodule

// File: tb/tb_binary_quiz_engine.sv
// ============================================================================
// tb_binary_quiz_engine
// ----------------------------------------------------------------------------
// Directed bench for binary_quiz_engine with WIDTH=4, ROUNDS=2, LIVES=2,
// TIMEOUT_CYC=8, STABLE_CYC=2. A reference LFSR built from the tap list
// predicts each target. All outputs are packed into one word and compared
// against hand-built expected words:
//   {target_valid, target[3:0], score[7:0], lives_left[3:0],
//    hit_pulse, miss_pulse, game_over, win}
// ============================================================================
module tb_binary_quiz_engine;

    localparam int          WIDTH       = 4;
    localparam int          ROUNDS      = 2;
    localparam int          LIVES       = 2;
    localparam int          TIMEOUT_CYC = 8;
    localparam int          STABLE_CYC  = 2;
    localparam logic [15:0] SEED        = 16'hACE1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             timed;
    logic [WIDTH-1:0] guess;
    logic [WIDTH-1:0] target;
    logic             target_valid;
    logic [7:0]       score;
    logic [3:0]       lives_left;
    logic             hit_pulse;
    logic             miss_pulse;
    logic             game_over;
    logic             win;

    int vec_count = 0;
    int err_count = 0;

    binary_quiz_engine #(
        .WIDTH       (WIDTH),
        .ROUNDS      (ROUNDS),
        .LIVES       (LIVES),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .STABLE_CYC  (STABLE_CYC),
        .SEED        (SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .timed        (timed),
        .guess        (guess),
        .target       (target),
        .target_valid (target_valid),
        .score        (score),
        .lives_left   (lives_left),
        .hit_pulse    (hit_pulse),
        .miss_pulse   (miss_pulse),
        .game_over    (game_over),
        .win          (win)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^16 + x^14 + x^13 + x^11, shifting left.
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [20:0] outs();
        return {target_valid, target, score, lives_left, hit_pulse, miss_pulse, game_over, win};
    endfunction

    // Advance one cycle, then settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in a LOAD cycle. The task follows the reference LFSR until the
    // draw is accepted and returns the target that should be in PLAY now.
    task automatic wait_load(output logic [3:0] tgt);
        logic [3:0] cand;
        tgt = 4'h0;
        for (int i = 0; i < 64; i++) begin
            cand = m_lfsr[3:0];
            step();
            if (cand != 4'h0 && cand != guess) begin
                tgt = cand;
                return;
            end
        end
        vec_count++;
        err_count++;
        $display("FAIL load_timeout: target_valid=%b after 64 LOAD cycles, want an accepted draw", target_valid);
    endtask

    task automatic test_reset();
        logic [20:0] exp;
        rst = 1'b1; start = 1'b0; timed = 1'b0; guess = 4'h0;
        step(); step();
        exp = {1'b0, 4'h0, 8'd0, 4'd2, 4'b0000};
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL reset_state: got %h want %h", outs(), exp); end
        // Reset wins over start in the same cycle.
        start = 1'b1;
        step();
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL reset_over_start: got %h want %h", outs(), exp); end
        rst = 1'b0; start = 1'b0;
        step();
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL idle_hold: got %h want %h", outs(), exp); end
    endtask

    task automatic test_free_play();
        logic [20:0] exp;
        logic [3:0]  t;
        guess = 4'h0; timed = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        exp = {1'b0, 4'h0, 8'd0, 4'd2, 4'b0000};
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL free_load: got %h want %h", outs(), exp); end
        for (int r = 1; r <= 2; r++) begin
            wait_load(t);
            exp = {1'b1, t, 8'(r - 1), 4'd2, 4'b0000};
            vec_count++;
            if (outs() !== exp) begin err_count++; $display("FAIL free_play_r%0d: got %h want %h", r, outs(), exp); end
            guess = t;
            step();
            vec_count++;
            if (outs() !== exp) begin err_count++; $display("FAIL free_match1_r%0d: got %h want %h", r, outs(), exp); end
            step();
            exp = {1'b0, 4'h0, 8'(r), 4'd2, 4'b1000};
            vec_count++;
            if (outs() !== exp) begin err_count++; $display("FAIL free_hit_r%0d: got %h want %h", r, outs(), exp); end
            guess = 4'h0;
            step();
            if (r == 1) exp = {1'b0, 4'h0, 8'd1, 4'd2, 4'b0000};
            else        exp = {1'b0, 4'h0, 8'd2, 4'd2, 4'b0011};
            vec_count++;
            if (outs() !== exp) begin err_count++; $display("FAIL free_after_hit_r%0d: got %h want %h", r, outs(), exp); end
        end
        step();
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL free_over_hold: got %h want %h", outs(), exp); end
    endtask

    task automatic test_glitch();
        logic [20:0] exp;
        logic [3:0]  t;
        // Restart from OVER: score and flags clear on the way into LOAD.
        guess = 4'h0; timed = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        exp = {1'b0, 4'h0, 8'd0, 4'd2, 4'b0000};
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL restart_load: got %h want %h", outs(), exp); end
        wait_load(t);
        exp = {1'b1, t, 8'd0, 4'd2, 4'b0000};
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL glitch_play: got %h want %h", outs(), exp); end
        start = 1'b1;   // must be ignored while playing
        guess = t;
        step();
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL glitch_c1: got %h want %h", outs(), exp); end
        guess = t ^ 4'hF;
        step();
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL glitch_c2: got %h want %h", outs(), exp); end
        guess = t;
        step();
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL glitch_c3: got %h want %h", outs(), exp); end
        step();
        exp = {1'b0, 4'h0, 8'd1, 4'd2, 4'b1000};
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL glitch_hit: got %h want %h", outs(), exp); end
        start = 1'b0; guess = 4'h0;
        step();
        wait_load(t);
        exp = {1'b1, t, 8'd1, 4'd2, 4'b0000};
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL glitch_round2: got %h want %h", outs(), exp); end
    endtask

    task automatic test_reset_mid_game();
        logic [20:0] exp;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp = {1'b0, 4'h0, 8'd0, 4'd2, 4'b0000};
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL midgame_reset: got %h want %h", outs(), exp); end
        step();
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL midgame_idle: got %h want %h", outs(), exp); end
    endtask

    task automatic test_timed();
        logic [20:0] exp;
        logic [3:0]  t;
        guess = 4'h0; timed = 1'b1; start = 1'b1;
        step();
        start = 1'b0; timed = 1'b0;   // mode was latched at start
        for (int r = 1; r <= 2; r++) begin
            wait_load(t);
            exp = {1'b1, t, 8'd0, 4'(3 - r), 4'b0000};
            vec_count++;
            if (outs() !== exp) begin err_count++; $display("FAIL timed_play_r%0d: got %h want %h", r, outs(), exp); end
            for (int c = 2; c <= 8; c++) begin
                step();
                vec_count++;
                if (outs() !== exp) begin err_count++; $display("FAIL timed_c%0d_r%0d: got %h want %h", c, r, outs(), exp); end
            end
            step();
            exp = {1'b0, 4'h0, 8'd0, 4'(2 - r), 4'b0100};
            vec_count++;
            if (outs() !== exp) begin err_count++; $display("FAIL timed_miss_r%0d: got %h want %h", r, outs(), exp); end
            step();
            if (r == 1) exp = {1'b0, 4'h0, 8'd0, 4'd1, 4'b0000};
            else        exp = {1'b0, 4'h0, 8'd0, 4'd0, 4'b0010};
            vec_count++;
            if (outs() !== exp) begin err_count++; $display("FAIL timed_after_miss_r%0d: got %h want %h", r, outs(), exp); end
        end
    endtask

    task automatic test_collision();
        logic [20:0] exp;
        logic [3:0]  t;
        guess = 4'h0; timed = 1'b1; start = 1'b1;
        step();
        start = 1'b0; timed = 1'b0;
        wait_load(t);
        exp = {1'b1, t, 8'd0, 4'd2, 4'b0000};
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL coll_play: got %h want %h", outs(), exp); end
        for (int c = 2; c <= 7; c++) step();
        guess = t;      // matches on PLAY cycles 7 and 8
        step();
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL coll_c8: got %h want %h", outs(), exp); end
        step();
        exp = {1'b0, 4'h0, 8'd1, 4'd2, 4'b1000};
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL coll_hit: got %h want %h", outs(), exp); end
        step();
        exp = {1'b0, 4'h0, 8'd1, 4'd2, 4'b0000};
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL coll_after: got %h want %h", outs(), exp); end
    endtask

    task automatic test_redraw();
        logic [20:0] exp;
        logic [3:0]  t;
        rst = 1'b1;
        step();
        rst = 1'b0; guess = 4'h0; timed = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        guess = m_lfsr[3:0];   // first LOAD candidate: must be rejected
        step();
        exp = {1'b0, 4'h0, 8'd0, 4'd2, 4'b0000};
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL redraw_reject: got %h want %h", outs(), exp); end
        wait_load(t);
        exp = {1'b1, t, 8'd0, 4'd2, 4'b0000};
        vec_count++;
        if (outs() !== exp) begin err_count++; $display("FAIL redraw_accept: got %h want %h", outs(), exp); end
        vec_count++;
        if (target == guess || target == 4'h0) begin
            err_count++;
            $display("FAIL redraw_distinct: target=%h guess=%h, want target nonzero and != guess", target, guess);
        end
    endtask

    initial begin
        test_reset();
        test_free_play();
        test_glitch();
        test_reset_mid_game();
        test_timed();
        test_collision();
        test_redraw();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_count);
        $fatal(1);
    end

endmodule

// File: doc/binary_quiz_engine.md
BINARY_QUIZ_ENGINE -- requirements
Module: binary_quiz_engine

Interface
REQ-001 Parameter WIDTH, default 8: guess/target width; legal range 2..16.
REQ-002 Parameter ROUNDS, default 10: hits needed to win; legal range 1..255.
REQ-003 Parameter LIVES, default 3: misses allowed in timed mode; legal range 1..15.
REQ-004 Parameter TIMEOUT_CYC, default 50_000_000: per-round time limit in clk cycles; legal minimum 2.
REQ-005 Parameter STABLE_CYC, default 1024: cycles guess must equal target to score; legal minimum 1.
REQ-006 Parameter SEED, default 16'hACE1: LFSR reset value; must be nonzero.
REQ-007 clk  in  1  single system clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 start  in  1  level, sampled each cycle; starts or restarts a game.
REQ-010 timed  in  1  mode select, sampled only on game start: 0 = free play, 1 = timed with lives.
REQ-011 guess  in  WIDTH  player's DIP-switch value.
REQ-012 target  out  WIDTH  current number to reproduce; 0 when not in PLAY.
REQ-013 target_valid  out  1  high exactly while in PLAY.
REQ-014 score  out  8  hits this game.
REQ-015 lives_left  out  4  remaining lives; LIVES in free play, never decremented.
REQ-016 hit_pulse / miss_pulse  out  1 each  one-cycle strobes.
REQ-017 game_over / win  out  1 each  high in OVER; win = 1 only if score reached ROUNDS.

Function
REQ-018 Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, shifts every cycle in every state except during reset.
REQ-019 States: IDLE, LOAD, PLAY, HIT, MISS, OVER; all outputs registered.
REQ-020 IDLE: start=1 -> LOAD next cycle; latch timed; score=0; lives_left=LIVES.
REQ-021 LOAD: candidate = LFSR[WIDTH-1:0]; accept only if candidate != 0 and != guess, else stay in LOAD and retry next cycle.
REQ-022 LOAD accept: target <= candidate; enter PLAY; match counter and round timer cleared to 0.
REQ-023 PLAY: match counter increments each cycle guess == target, clears to 0 the cycle guess differs.
REQ-024 PLAY: match counter reaching STABLE_CYC-1 while guess == target -> HIT.
REQ-025 PLAY timed=1: round timer increments each cycle; at TIMEOUT_CYC-1 with no hit that cycle -> MISS.
REQ-026 PLAY timed=0: round timer held at 0; no MISS possible.
REQ-027 Hit and timeout in same cycle: HIT takes priority.
REQ-028 HIT (one cycle): hit_pulse=1, score+1; if new score == ROUNDS -> OVER with win=1, else LOAD.
REQ-029 MISS (one cycle): miss_pulse=1, lives_left-1; if new value 0 -> OVER with win=0, else LOAD (new target).
REQ-030 OVER: score, lives_left, win held; target=0; start=1 -> clear score, lives_left=LIVES, relatch timed, -> LOAD.
REQ-031 start in LOAD/PLAY/HIT/MISS is ignored.
REQ-032 Latency: start to target_valid >= 2 cycles; exact hit registers STABLE_CYC cycles after the first matching PLAY cycle.
REQ-033 score saturates at 255, unreachable with legal ROUNDS.

Reset
REQ-034 rst=1 at any edge, including mid-game: state IDLE, LFSR=SEED, all counters 0, target=0, score=0, lives_left=LIVES, all pulses/flags 0.
REQ-035 rst has priority over start and every other input in the same cycle.

Verification (WIDTH=4, ROUNDS=2, LIVES=2, TIMEOUT_CYC=8, STABLE_CYC=2)
REQ-036 Free play: start=1, timed=0; drive guess=target for 2 PLAY cycles, twice -> two hit_pulses, score=2, game_over=1, win=1.
REQ-037 Glitch: guess=target 1 cycle, wrong 1 cycle, then correct 2 cycles -> exactly one hit_pulse, on the 2nd consecutive match.
REQ-038 Timed: start, timed=1, guess never matches -> miss_pulse after 8 PLAY cycles, lives_left=1; next miss -> game_over=1, win=0, score=0.
REQ-039 Redraw: hold guess at the LFSR candidate of the first LOAD cycle -> LOAD stays, accepted target != guess and != 0.
REQ-040 Collision: guess matches on the 8th timed PLAY cycle with match counter=1 -> hit_pulse, no miss_pulse, lives_left unchanged.
REQ-041 Reset mid-PLAY with score=1 -> next cycle IDLE, score=0, target=0, lives_left=2; OVER + start -> fresh game, score=0.
